dcache_refill: RTL and testbench

DCACHE_REFILL -- requirements
Module: dcache_refill

---
 rtl/dcache_refill_pkg.sv | 13 +
 rtl/dcache_wb_mux.sv | 10 +
 rtl/dcache_refill.sv | 94 +++++++++
 tb/tb_dcache_refill.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_refill_pkg.sv
// dcache_refill_pkg: shared cache types for the refill engine (states, line size, tag entry)
package dcache_refill_pkg;
  localparam int CL_LINE_WORDS = 8;
  localparam int TAG_W = 20;
  typedef enum logic [2:0] {IDLE, WB_ADDR, WB_DATA, RF_ADDR, RF_DATA, TAG_WR, DONE} state_t;
  typedef struct packed {
    logic valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;
  function automatic tag_entry_t make_tag(input logic [TAG_W-1:0] t);
    return {1'b1, t};
  endfunction
endpackage

// File: rtl/dcache_wb_mux.sv
// dcache_wb_mux: selects one 32-bit word of the captured victim line for the write burst
module dcache_wb_mux #(
  parameter int LINE_WORDS = 8
) (
  input  logic [32*LINE_WORDS-1:0] line,
  input  logic [2:0]               sel,
  output logic [31:0]              word
);
  always_comb word = line[32*sel +: 32];
endmodule

// File: rtl/dcache_refill.sv
// dcache_refill: miss handler that writes back a dirty victim, refills the line, then updates the tag
module dcache_refill
  import dcache_refill_pkg::*;
#(
  parameter int LINE_WORDS = CL_LINE_WORDS,
  parameter int INDEX_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic                    vic_valid,
  input  logic                    vic_dirty,
  input  logic [19:0]             vic_tag,
  input  logic [32*LINE_WORDS-1:0] vic_line,
  output logic                    aw_valid,
  input  logic                    aw_ready,
  output logic [31:0]             aw_addr,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [31:0]             w_data,
  output logic                    w_last,
  output logic                    ar_valid,
  input  logic                    ar_ready,
  output logic [31:0]             ar_addr,
  input  logic                    r_valid,
  input  logic [31:0]             r_data,
  input  logic                    r_last,
  output logic                    tag_wen,
  output logic [INDEX_W-1:0]      tag_index,
  output logic [20:0]             tag_wdata,
  output logic                    data_wen,
  output logic [INDEX_W-1:0]      data_index,
  output logic [2:0]              data_word,
  output logic [31:0]             data_wdata,
  output logic                    done
);
  localparam logic [2:0] LAST = 3'(LINE_WORDS - 1);
  state_t state, state_d;
  logic [2:0] beat, beat_d;
  logic [31:5] addr_q;
  logic [19:0] vtag_q;
  logic [32*LINE_WORDS-1:0] line_q;
  logic hs;
  dcache_wb_mux #(.LINE_WORDS(LINE_WORDS)) u_mux (.line(line_q), .sel(beat), .word(w_data));
  assign req_ready  = state == IDLE;
  assign aw_valid   = state == WB_ADDR;
  assign aw_addr    = {vtag_q, addr_q[11:5], 5'b0};
  assign w_valid    = state == WB_DATA;
  assign w_last     = w_valid && beat == LAST;
  assign ar_valid   = state == RF_ADDR;
  assign ar_addr    = {addr_q, 5'b0};
  assign data_wen   = state == RF_DATA && r_valid;
  assign data_index = addr_q[5 +: INDEX_W];
  assign data_word  = beat;
  assign data_wdata = r_data;
  assign tag_wen    = state == TAG_WR;
  assign tag_index  = addr_q[5 +: INDEX_W];
  assign tag_wdata  = make_tag(addr_q[31:12]);
  assign done       = state == DONE;
  assign hs         = (w_valid && w_ready) || data_wen;
  // beat is held at zero outside the data phases, so entry always starts from word 0
  always_comb begin
    state_d = state;
    beat_d = (state == WB_DATA || state == RF_DATA) ? beat + 3'(hs) : 3'd0;
    case (state)
      IDLE:    if (req_valid) state_d = (vic_valid && vic_dirty) ? WB_ADDR : RF_ADDR;
      WB_ADDR: if (aw_ready) state_d = WB_DATA;
      WB_DATA: if (w_ready && w_last) state_d = RF_ADDR;
      RF_ADDR: if (ar_ready) state_d = RF_DATA;
      RF_DATA: if (r_valid && (r_last || beat == LAST)) state_d = TAG_WR;
      TAG_WR:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
    end else begin
      state <= state_d;
      beat <= beat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      addr_q <= req_addr[31:5];
      vtag_q <= vic_tag;
      line_q <= vic_line;
    end
  end
endmodule

// File: tb/tb_dcache_refill.sv
// tb_dcache_refill: scoreboard bench driving a scripted memory against the refill engine
module tb_dcache_refill;
  logic clk = 0, rst;
  logic req_valid, req_ready, vic_valid, vic_dirty;
  logic [31:0] req_addr;
  logic [19:0] vic_tag;
  logic [255:0] vic_line;
  logic aw_valid, aw_ready, w_valid, w_ready, w_last, ar_valid, ar_ready;
  logic [31:0] aw_addr, w_data, ar_addr, r_data, data_wdata;
  logic r_valid, r_last, tag_wen, data_wen, done;
  logic [6:0] tag_index, data_index;
  logic [20:0] tag_wdata;
  logic [2:0] data_word;
  int checks = 0, failures = 0;
  logic [31:0] wq[$];
  logic [41:0] dq[$];

  always #5 clk = ~clk;

  dcache_refill dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .vic_valid(vic_valid), .vic_dirty(vic_dirty), .vic_tag(vic_tag), .vic_line(vic_line),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_data(r_data), .r_last(r_last),
    .tag_wen(tag_wen), .tag_index(tag_index), .tag_wdata(tag_wdata),
    .data_wen(data_wen), .data_index(data_index), .data_word(data_word), .data_wdata(data_wdata),
    .done(done)
  );

  task automatic run_miss(input logic [31:0] addr, input logic vv, input logic vd, input logic [19:0] vt,
                          input int wstall_beat, input int wstall_len, input logic [7:0] rgap,
                          input int rlast_beat, input int rst_beat, input bit hold,
                          output int cyc, output int ndw, output int ntag, output int ndone);
    logic [255:0] line;
    logic [31:0] rd[8];
    logic [41:0] got;
    int wb, rb, scnt, last_dw;
    bit rph, gapped, dirty;
    dirty = vv && vd;
    for (int i = 0; i < 8; i++) begin
      line[32*i +: 32] = $urandom;
      rd[i] = $urandom;
      if (dirty) wq.push_back(line[32*i +: 32]);
      if (i <= rlast_beat && (rst_beat < 0 || i < rst_beat)) dq.push_back({addr[11:5], 3'(i), rd[i]});
    end
    ndw = 0; ntag = 0; ndone = 0; cyc = -1;
    wb = 0; rb = 0; scnt = 0; rph = 0; gapped = 0; last_dw = -10;
    for (int it = 0; it < 200; it++) begin
      @(negedge clk);
      req_valid = (it == 0) || hold;
      if (it == 0) begin
        req_addr = addr; vic_valid = vv; vic_dirty = vd; vic_tag = vt; vic_line = line;
      end
      w_ready = !(w_valid && wb == wstall_beat && scnt < wstall_len);
      if (!w_ready) scnt++;
      r_last = 0;
      if (rst_beat >= 0 && rph && rb == rst_beat) begin
        rst = 1; r_valid = 0;
      end else if (rph && rb <= rlast_beat && rgap[rb] && !gapped) begin
        r_valid = 0; gapped = 1;
      end else begin
        r_valid = rph && rb <= rlast_beat;
        r_last = r_valid && rb == rlast_beat;
        r_data = (rb < 8) ? rd[rb] : 32'h0;
        gapped = 0;
      end
      #1;
      if (rst) begin
        checks++;
        if (tag_wen !== 1'b0) begin failures++; $display("FAIL rst_tag: tag_wen=%b exp 0", tag_wen); end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || ar_valid !== 1'b0 || tag_wen !== 1'b0 || data_wen !== 1'b0) begin
          failures++;
          $display("FAIL rst_idle: req_ready=%b ar_valid=%b tag_wen=%b data_wen=%b exp 1 0 0 0",
                   req_ready, ar_valid, tag_wen, data_wen);
        end
        break;
      end
      if (it > 0) begin
        checks++;
        if (req_ready !== 1'b0) begin failures++; $display("FAIL busy_ready: it=%0d req_ready=%b exp 0", it, req_ready); end
      end
      if (aw_valid) begin
        checks++;
        if (aw_addr !== {vt, addr[11:5], 5'b0} || !dirty) begin
          failures++; $display("FAIL aw_addr: got %h exp %h dirty=%b", aw_addr, {vt, addr[11:5], 5'b0}, dirty);
        end
      end
      if (w_valid) begin
        checks++;
        if (wq.size() == 0 || w_data !== wq[0] || w_last !== (wb == 7)) begin
          failures++;
          $display("FAIL w_beat: beat=%0d w_data=%h w_last=%b exp %h %b", wb, w_data, w_last,
                   (wq.size() > 0) ? wq[0] : 32'hx, wb == 7);
        end
        if (w_ready && wq.size() > 0) begin void'(wq.pop_front()); wb++; end
      end
      if (ar_valid) begin
        checks++;
        if (ar_addr !== {addr[31:5], 5'b0} || (dirty && wb < 8)) begin
          failures++; $display("FAIL ar_addr: got %h exp %h wbeats=%0d", ar_addr, {addr[31:5], 5'b0}, wb);
        end
        rph = 1;
      end
      checks++;
      if (data_wen !== r_valid) begin failures++; $display("FAIL data_wen: got %b exp %b", data_wen, r_valid); end
      if (data_wen) begin
        got = {data_index, data_word, data_wdata};
        checks++;
        if (dq.size() == 0 || got !== dq[0]) begin
          failures++; $display("FAIL data_wr: got %h exp %h", got, (dq.size() > 0) ? dq[0] : 42'hx);
        end
        if (dq.size() > 0) void'(dq.pop_front());
        ndw++; last_dw = it;
      end
      if (r_valid) rb++;
      if (tag_wen) begin
        ntag++;
        checks++;
        if (tag_wdata !== {1'b1, addr[31:12]} || tag_index !== addr[11:5] || it != last_dw + 1) begin
          failures++;
          $display("FAIL tag_wr: wdata=%h index=%h it=%0d exp %h %h it=%0d", tag_wdata, tag_index, it,
                   {1'b1, addr[31:12]}, addr[11:5], last_dw + 1);
        end
      end
      if (done) begin ndone++; cyc = it; break; end
    end
    if (cyc < 0 && rst_beat < 0) begin failures++; $display("FAIL timeout: no done within 200 cycles"); end
    checks++;
    if (dq.size() != 0 || wq.size() != 0) begin
      failures++; $display("FAIL leftover: data=%0d w=%0d exp 0 0", dq.size(), wq.size());
    end
    dq.delete(); wq.delete();
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 0; req_addr = 0; vic_valid = 0; vic_dirty = 0; vic_tag = 0; vic_line = 0;
    aw_ready = 1; w_ready = 1; ar_ready = 1; r_valid = 0; r_data = 0; r_last = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if ({req_ready, aw_valid, w_valid, w_last, ar_valid, data_wen, tag_wen, done} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset: got %b exp 10000000",
               {req_ready, aw_valid, w_valid, w_last, ar_valid, data_wen, tag_wen, done});
    end
  endtask

  task automatic check_run(input string name, input int cyc, input int ndw, input int ntag, input int ndone,
                           input int ecyc, input int endw, input int entag, input int endone);
    checks++;
    if (cyc != ecyc || ndw != endw || ntag != entag || ndone != endone) begin
      failures++;
      $display("FAIL %s: cycles=%0d writes=%0d tags=%0d dones=%0d exp %0d %0d %0d %0d",
               name, cyc, ndw, ntag, ndone, ecyc, endw, entag, endone);
    end
  endtask

  task automatic test_clean_miss();
    int c, d, t, n;
    run_miss(32'h1234_5660, 0, 0, 20'h0, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("clean_miss", c, d, t, n, 11, 8, 1, 1);
  endtask

  task automatic test_dirty_victim();
    int c, d, t, n;
    run_miss(32'h1234_5660, 1, 1, 20'hABCDE, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("dirty_victim", c, d, t, n, 20, 8, 1, 1);
  endtask

  task automatic test_not_dirty();
    int c, d, t, n;
    run_miss(32'hCAFE_F7A4, 1, 0, 20'h11111, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("valid_clean", c, d, t, n, 11, 8, 1, 1);
    run_miss(32'h0000_0020, 0, 1, 20'h22222, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("invalid_dirty", c, d, t, n, 11, 8, 1, 1);
  endtask

  task automatic test_w_stall();
    int c, d, t, n;
    run_miss(32'h8765_4FE0, 1, 1, 20'h5A5A5, 4, 3, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("w_stall", c, d, t, n, 23, 8, 1, 1);
  endtask

  task automatic test_r_gaps();
    int c, d, t, n;
    run_miss(32'h1234_5660, 0, 0, 20'h0, -1, 0, 8'b1010_0100, 7, -1, 0, c, d, t, n);
    check_run("r_gaps", c, d, t, n, 14, 8, 1, 1);
  endtask

  task automatic test_early_rlast();
    int c, d, t, n;
    run_miss(32'h0BAD_F00C, 0, 0, 20'h0, -1, 0, 8'h0, 5, -1, 0, c, d, t, n);
    check_run("early_rlast", c, d, t, n, 9, 6, 1, 1);
  endtask

  task automatic test_reset_mid();
    int c, d, t, n;
    run_miss(32'h4444_4440, 1, 1, 20'h33333, -1, 0, 8'h0, 7, 3, 0, c, d, t, n);
    check_run("reset_mid", c, d, t, n, -1, 3, 0, 0);
    run_miss(32'h5555_5560, 0, 0, 20'h0, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("after_reset", c, d, t, n, 11, 8, 1, 1);
  endtask

  task automatic test_back_to_back();
    int c, d, t, n;
    run_miss(32'h1357_9BC0, 0, 0, 20'h0, -1, 0, 8'h0, 7, -1, 1, c, d, t, n);
    check_run("b2b_first", c, d, t, n, 11, 8, 1, 1);
    run_miss(32'h2468_ACE0, 1, 1, 20'hFEDCB, -1, 0, 8'h0, 7, -1, 0, c, d, t, n);
    check_run("b2b_second", c, d, t, n, 20, 8, 1, 1);
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_victim();
    test_not_dirty();
    test_w_stall();
    test_r_gaps();
    test_early_rlast();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    req_valid = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
